// File: rtl/compare_counter.sv
// compare_counter: edge-selected up/down counter with synchronous clear/load,
// live compare register (free-run or clear-on-compare), registered event
// pulses and write-1-to-clear sticky flags.
// Optional feature macro: COUNTER_SYNC_EN -- adds a 2-flop synchronizer on
// CountIn ahead of edge detection (CountIn may then be asynchronous).
module compare_counter #(
  parameter int BIT_WIDTH = 8
) (
  input  logic                 CounterClock,
  input  logic                 CounterResetN,
  input  logic                 CountIn,
  input  logic [1:0]           CounterEdge,
  input  logic                 CountDown,
  input  logic                 CtcMode,
  input  logic                 CounterClear,
  input  logic                 Load,
  input  logic [BIT_WIDTH-1:0] LoadValue,
  input  logic [BIT_WIDTH-1:0] Compare,
  input  logic [2:0]           FlagClear,
  output logic [BIT_WIDTH-1:0] TCNT,
  output logic                 Overflow,
  output logic                 Underflow,
  output logic                 CompareMatch,
  output logic                 OvfFlag,
  output logic                 UdfFlag,
  output logic                 CmpFlag
);

  logic                 w_s;
  logic                 r_prev;
  logic                 w_tick;
  logic [BIT_WIDTH-1:0] w_max;
  logic [BIT_WIDTH-1:0] w_cnt_nxt;
  logic                 w_ovf;
  logic                 w_udf;
  logic                 w_cmp;

  assign w_max = '1;

`ifdef COUNTER_SYNC_EN
  // Edge detection stays blocked until the synchronizer and history flop
  // have all been filled from the live CountIn after reset release.
  localparam int VLD_DEPTH = 3;
  logic [1:0] r_sync;

  // Two-flop synchronizer for an asynchronous count source
  always_ff @(posedge CounterClock or negedge CounterResetN) begin
    if (!CounterResetN) r_sync <= '0;
    else                r_sync <= {r_sync[0], CountIn};
  end
  assign w_s = r_sync[1];
`else
  localparam int VLD_DEPTH = 1;
  assign w_s = CountIn;
`endif

  logic [VLD_DEPTH-1:0] r_vld_pipe;

  // History flop plus valid shift register gating edge detection after reset
  always_ff @(posedge CounterClock or negedge CounterResetN) begin
    if (!CounterResetN) begin
      r_prev     <= 1'b0;
      r_vld_pipe <= '0;
    end else begin
      r_prev     <= w_s;
      r_vld_pipe <= (r_vld_pipe << 1) | VLD_DEPTH'(1);
    end
  end

  // Edge select; a change of CounterEdge alone never makes a tick
  always_comb begin
    w_tick = 1'b0;
    case (CounterEdge)
      2'b01:   w_tick = w_s & ~r_prev;
      2'b10:   w_tick = ~w_s & r_prev;
      2'b11:   w_tick = w_s ^ r_prev;
      default: w_tick = 1'b0;
    endcase
    w_tick = w_tick & r_vld_pipe[VLD_DEPTH-1];
  end

  // Next count and events: clear > load > tick; clear/load swallow the tick
  always_comb begin
    w_cnt_nxt = TCNT;
    w_ovf     = 1'b0;
    w_udf     = 1'b0;
    w_cmp     = 1'b0;
    if (CounterClear) begin
      w_cnt_nxt = '0;
    end else if (Load) begin
      w_cnt_nxt = LoadValue;
    end else if (w_tick) begin
      // Match is on the pre-tick value in every mode and direction
      w_cmp = (TCNT == Compare);
      if (!CountDown) begin
        if (CtcMode && TCNT == Compare) begin
          w_cnt_nxt = '0;
        end else if (TCNT == w_max) begin
          w_cnt_nxt = '0;
          w_ovf     = 1'b1;
        end else begin
          w_cnt_nxt = TCNT + BIT_WIDTH'(1);
        end
      end else begin
        if (TCNT == '0) begin
          w_udf     = 1'b1;
          w_cnt_nxt = CtcMode ? Compare : w_max;
        end else begin
          w_cnt_nxt = TCNT - BIT_WIDTH'(1);
        end
      end
    end
  end

  // Count, registered pulses and sticky flags (set wins over clear)
  always_ff @(posedge CounterClock or negedge CounterResetN) begin
    if (!CounterResetN) begin
      TCNT         <= '0;
      Overflow     <= 1'b0;
      Underflow    <= 1'b0;
      CompareMatch <= 1'b0;
      OvfFlag      <= 1'b0;
      UdfFlag      <= 1'b0;
      CmpFlag      <= 1'b0;
    end else begin
      TCNT         <= w_cnt_nxt;
      Overflow     <= w_ovf;
      Underflow    <= w_udf;
      CompareMatch <= w_cmp;
      OvfFlag      <= w_ovf | (OvfFlag & ~FlagClear[0]);
      UdfFlag      <= w_udf | (UdfFlag & ~FlagClear[1]);
      CmpFlag      <= w_cmp | (CmpFlag & ~FlagClear[2]);
    end
  end

endmodule

// File: tb/tb_compare_counter.sv
// tb_compare_counter: randomized + directed stimulus against a behavioural
// model of compare_counter (BIT_WIDTH=8). Model latency follows COUNTER_SYNC_EN.
module tb_compare_counter;
  localparam int W   = 8;
  localparam int MAX = (1 << W) - 1;
`ifdef COUNTER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic         gclk;
  logic         grst_n;
  logic         count_in;
  logic [1:0]   cnt_edge;
  logic         cnt_down;
  logic         ctc;
  logic         clr;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] cmp_val;
  logic [2:0]   flag_clr;
  logic [W-1:0] tcnt;
  logic         ovf, udf, cmpm, ovf_f, udf_f, cmp_f;

  compare_counter #(.BIT_WIDTH(W)) dut (
    .CounterClock(gclk), .CounterResetN(grst_n), .CountIn(count_in),
    .CounterEdge(cnt_edge), .CountDown(cnt_down), .CtcMode(ctc),
    .CounterClear(clr), .Load(load), .LoadValue(load_val), .Compare(cmp_val),
    .FlagClear(flag_clr), .TCNT(tcnt), .Overflow(ovf), .Underflow(udf),
    .CompareMatch(cmpm), .OvfFlag(ovf_f), .UdfFlag(udf_f), .CmpFlag(cmp_f)
  );

  initial begin
    gclk = 1'b0;
    forever #5 gclk = ~gclk;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: CountIn as seen by the counter is the value applied
  // LAT edges earlier; edges need one real previous sample after reset.
  int m_cnt;
  bit m_ovf, m_udf, m_cmp, m_fo, m_fu, m_fc;
  bit hist[$];

  task automatic model_reset();
    m_cnt = 0; m_ovf = 0; m_udf = 0; m_cmp = 0;
    m_fo = 0; m_fu = 0; m_fc = 0;
    hist.delete();
  endtask

  task automatic model_step();
    int k;
    bit s, p, tick;
    hist.push_back(count_in);
    k = hist.size() - 1;
    s = (k - LAT >= 0)     ? hist[k-LAT]   : 1'b0;
    p = (k - 1 - LAT >= 0) ? hist[k-1-LAT] : 1'b0;
    case (cnt_edge)
      2'd1:    tick = s && !p;
      2'd2:    tick = !s && p;
      2'd3:    tick = s != p;
      default: tick = 1'b0;
    endcase
    if (k < LAT + 1) tick = 1'b0;
    m_ovf = 0; m_udf = 0; m_cmp = 0;
    if (clr)       m_cnt = 0;
    else if (load) m_cnt = int'(load_val);
    else if (tick) begin
      m_cmp = (m_cnt == int'(cmp_val));
      if (!cnt_down) begin
        if (ctc && m_cnt == int'(cmp_val)) m_cnt = 0;
        else if (m_cnt == MAX) begin m_cnt = 0; m_ovf = 1; end
        else m_cnt = m_cnt + 1;
      end else begin
        if (m_cnt == 0) begin
          m_udf = 1;
          m_cnt = ctc ? int'(cmp_val) : MAX;
        end else m_cnt = m_cnt - 1;
      end
    end
    m_fo = m_ovf | (m_fo & !flag_clr[0]);
    m_fu = m_udf | (m_fu & !flag_clr[1]);
    m_fc = m_cmp | (m_fc & !flag_clr[2]);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".tcnt"}, 32'(tcnt), 32'(m_cnt));
    chk({tag, ".ovf"},  32'(ovf),   32'(m_ovf));
    chk({tag, ".udf"},  32'(udf),   32'(m_udf));
    chk({tag, ".cmp"},  32'(cmpm),  32'(m_cmp));
    chk({tag, ".ovff"}, 32'(ovf_f), 32'(m_fo));
    chk({tag, ".udff"}, 32'(udf_f), 32'(m_fu));
    chk({tag, ".cmpf"}, 32'(cmp_f), 32'(m_fc));
  endtask

  // Optional CountIn auto-toggle every tog_per cycles (0 = off)
  int tog_per = 0;
  int tog_cnt = 0;

  task automatic step(input string tag);
    @(posedge gclk);
    model_step();
    #1;
    chk_all(tag);
    if (tog_per > 0) begin
      tog_cnt++;
      if (tog_cnt >= tog_per) begin
        count_in = ~count_in;
        tog_cnt  = 0;
      end
    end
  endtask

  // Reset asserted between edges; outputs must clear without a clock
  task automatic async_reset();
    #1 grst_n = 1'b0;
    #1;
    model_reset();
    chk_all("async_rst");
    #1 grst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic [W-1:0] t0;
    int down_exp[4] = '{1, 0, 4, 3};

    grst_n = 1'b0; count_in = 0; cnt_edge = 2'b00; cnt_down = 0; ctc = 0;
    clr = 0; load = 0; load_val = '0; cmp_val = '0; flag_clr = '0;
    model_reset();
    #7;
    chk_all("reset");
    #1 grst_n = 1'b1;

    // Free-run up, rising edges, CountIn toggles every 10 clocks
    cmp_val = 8'd200; cnt_edge = 2'b01; tog_per = 10;
    for (int i = 0; i < 256 * 20 + 40; i++) step("freerun");
    chk("freerun_ovf_flag", 32'(ovf_f), 32'd1);
    flag_clr = 3'b001;
    step("flagclr");
    flag_clr = 3'b000;
    chk("freerun_flag_cleared", 32'(ovf_f), 32'd0);

    // CTC up with Compare=9, count on both edges
    clr = 1; step("ctc_clr"); clr = 0;
    cmp_val = 8'd9; ctc = 1; cnt_edge = 2'b11; tog_per = 1; tog_cnt = 0;
    for (int i = 0; i < 45; i++) step("ctc9");
    n = 0;
    while (m_cnt != 5 && n < 40) begin step("ctc_wait5"); n++; end
    chk("ctc_wait5_timeout", 32'(n < 40), 32'd1);
    cmp_val = 8'd3;
    for (int i = 0; i < 260; i++) step("ctc_missed");

    // Down count in CTC mode from a loaded 2
    cnt_down = 1; cmp_val = 8'd4; load = 1; load_val = 8'd2;
    step("down_load"); load = 0;
    chk("down_start", 32'(tcnt), 32'd2);
    for (int i = 0; i < 4; i++) begin
      step("down");
      chk("down_seq", 32'(tcnt), 32'(down_exp[i]));
    end

    // Priority: clear > load > tick, no events
    cnt_down = 0; ctc = 0; cmp_val = 8'd7;
    clr = 1; load = 1; load_val = 8'h80;
    step("prio_all");
    chk("prio_all_tcnt", 32'(tcnt), 32'd0);
    clr = 0;
    step("prio_load");
    chk("prio_load_tcnt", 32'(tcnt), 32'h80);
    load = 0;
    for (int i = 0; i < 6; i++) step("prio_after");

    // Falling-edge and stop modes
    cnt_edge = 2'b10; tog_per = 2;
    for (int i = 0; i < 24; i++) step("fall");
    cnt_edge = 2'b00;
    t0 = tcnt;
    for (int i = 0; i < 20; i++) step("stop");
    chk("stop_hold", 32'(tcnt), 32'(t0));

    // Latency: rising edge presented after an edge appears LAT+1 edges later
    tog_per = 0; count_in = 0; cnt_edge = 2'b01;
    for (int i = 0; i < 5; i++) step("lat_idle");
    t0 = tcnt; count_in = 1; n = 0;
    while (tcnt == t0 && n < 10) begin step("lat_wait"); n++; end
    chk("latency", 32'(n), 32'(LAT + 1));

    // Reset corner: CountIn high through release, then async mid-count reset
    count_in = 1;
    async_reset();
    for (int i = 0; i < 8; i++) step("rst_hi");
    chk("rst_hi_hold", 32'(tcnt), 32'd0);
    count_in = 0;
    for (int i = 0; i < 4; i++) step("rst_lo");
    count_in = 1;
    for (int i = 0; i < 4; i++) step("rst_rise");
    chk("rst_first_edge", 32'(tcnt), 32'd1);

    // Random soak
    for (int i = 0; i < 3000; i++) begin
      count_in = ($urandom % 3) != 0 ? ~count_in : count_in;
      clr      = ($urandom % 32) == 0;
      load     = ($urandom % 32) == 0;
      load_val = W'($urandom_range(0, 2) == 0 ? $urandom_range(250, 255) : $urandom);
      flag_clr = ($urandom % 4) == 0 ? 3'($urandom) : 3'b000;
      if ($urandom % 64 == 0) cnt_down = ~cnt_down;
      if ($urandom % 64 == 0) ctc      = ~ctc;
      if ($urandom % 48 == 0) cnt_edge = 2'($urandom);
      if ($urandom % 48 == 0)
        cmp_val = W'($urandom % 2 ? $urandom_range(0, 15) : $urandom_range(240, 255));
      step("rand");
      if (i == 1500) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
